// File: rtl/cellram_pkg.sv
// Shared types and constants for the cellular RAM Wishbone controller.
package cellram_pkg;

    localparam int unsigned CntW          = 4;
    localparam int unsigned DefRdCycles   = 8;
    localparam int unsigned DefWrCycles   = 8;
    localparam int unsigned DefTurnCycles = 1;

    typedef logic [2:0] state_t;

    localparam state_t StIdle = 3'd0;
    localparam state_t StAcc0 = 3'd1;
    localparam state_t StTurn = 3'd2;
    localparam state_t StAcc1 = 3'd3;
    localparam state_t StAck  = 3'd4;

    function automatic logic is_acc(input state_t s);
        return (s == StAcc0) || (s == StAcc1);
    endfunction

endpackage

// File: rtl/cellram_wb_ctrl_if.sv
// Wishbone classic bus between the cellram arbiter (master) and the PSRAM controller (slave).
interface cellram_wb_ctrl_if;

    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/cellram_phase_timer.sv
// Loadable down-counter shared by the access and turnaround phases; done while the count is 1.
module cellram_phase_timer
    import cellram_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    output logic            done_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q > CntW'(1)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/cellram_wb_ctrl.sv
// Wishbone classic slave for the Nexys3 cellular RAM: a 32-bit access becomes two async halfwords.
// Define CELLRAM_WR_SKIP_EN to skip write halfwords whose two byte lanes are both masked.
module cellram_wb_ctrl
    import cellram_pkg::*;
#(
    parameter int unsigned RD_CYCLES   = DefRdCycles,
    parameter int unsigned WR_CYCLES   = DefWrCycles,
    parameter int unsigned TURN_CYCLES = DefTurnCycles
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    cellram_wb_ctrl_if.slave wb,
    output logic [22:0]      cr_addr_o,
    input  logic [15:0]      cr_dq_i,
    output logic [15:0]      cr_dq_o,
    output logic             cr_dq_oe,
    output logic             cr_ce_n,
    output logic             cr_oe_n,
    output logic             cr_we_n,
    output logic             cr_ub_n,
    output logic             cr_lb_n,
    output logic             cr_adv_n,
    output logic             cr_clk,
    output logic             cr_cre
);

    localparam logic [CntW-1:0] RdCnt   = CntW'(RD_CYCLES);
    localparam logic [CntW-1:0] WrCnt   = CntW'(WR_CYCLES);
    localparam logic [CntW-1:0] TurnCnt = CntW'(TURN_CYCLES);

    state_t      state_q, state_d;
    logic [21:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [31:0] rdat_q, rdat_d;
    logic        ack_q, ack_d;
    logic        rd_cap_q, rd_cap_d;
    logic        cap_hi_q, cap_hi_d;
    logic [22:0] addr_q, addr_d;
    logic [15:0] dq_q, dq_d;
    logic        dq_oe_q, dq_oe_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        ub_n_q, ub_n_d;
    logic        lb_n_q, lb_n_d;

    logic            req;
    logic            acc;
    logic            hi;
    logic            tmr_load;
    logic [CntW-1:0] tmr_val;
    logic            tmr_done;
    logic            skip_new0, skip_new1, skip_q1;
    logic            unused_adr;

    assign req        = wb.wb_cyc_i & wb.wb_stb_i;
    assign acc        = is_acc(state_q);
    assign hi         = (state_q == StAcc0);
    assign unused_adr = ^{wb.wb_adr_i[31:24], wb.wb_adr_i[1:0]};

`ifdef CELLRAM_WR_SKIP_EN
    assign skip_new0 = wb.wb_we_i & ~|wb.wb_sel_i[3:2];
    assign skip_new1 = wb.wb_we_i & ~|wb.wb_sel_i[1:0];
    assign skip_q1   = we_q & ~|sel_q[1:0];
`else
    assign skip_new0 = 1'b0;
    assign skip_new1 = 1'b0;
    assign skip_q1   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        case (state_q)
            // A request seen while ack is still high belongs to the finished transfer.
            StIdle: begin
                if (req && !ack_q) begin
                    adr_d = wb.wb_adr_i[23:2];
                    dat_d = wb.wb_dat_i;
                    sel_d = wb.wb_sel_i;
                    we_d  = wb.wb_we_i;
                    if (skip_new0) begin
                        state_d = skip_new1 ? StAck : StAcc1;
                    end else begin
                        state_d = StAcc0;
                    end
                end
            end
            StAcc0: begin
                if (tmr_done) begin
                    if (!wb.wb_cyc_i) begin
                        state_d = StIdle;
                    end else begin
                        state_d = skip_q1 ? StAck : StTurn;
                    end
                end
            end
            StTurn: begin
                if (tmr_done) begin
                    state_d = wb.wb_cyc_i ? StAcc1 : StIdle;
                end
            end
            StAcc1: begin
                if (tmr_done) begin
                    state_d = wb.wb_cyc_i ? StAck : StIdle;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign tmr_load = (state_d != state_q) && (is_acc(state_d) || (state_d == StTurn));
    assign tmr_val  = (state_d == StTurn) ? TurnCnt : (we_d ? WrCnt : RdCnt);

    cellram_phase_timer u_timer (
        .clk_i      (wb_clk),
        .rst_i      (wb_rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Pin registers follow state_q, so the bus lags the FSM by exactly one cycle.
    always_comb begin
        ce_n_d   = ~acc;
        oe_n_d   = ~(acc & ~we_q);
        we_n_d   = ~(acc & we_q);
        ub_n_d   = 1'b1;
        lb_n_d   = 1'b1;
        if (acc && we_q) begin
            {ub_n_d, lb_n_d} = hi ? ~sel_q[3:2] : ~sel_q[1:0];
        end else if (acc) begin
            {ub_n_d, lb_n_d} = 2'b00;
        end
        addr_d   = acc ? {adr_q, ~hi} : addr_q;
        dq_d     = acc ? (hi ? dat_q[31:16] : dat_q[15:0]) : dq_q;
        dq_oe_d  = we_q & (acc | ~we_n_q);
        ack_d    = (state_q == StAck);
        rd_cap_d = acc & tmr_done & ~we_q;
        cap_hi_d = hi;
        rdat_d   = rdat_q;
        if (rd_cap_q) begin
            if (cap_hi_q) begin
                rdat_d[31:16] = cr_dq_i;
            end else begin
                rdat_d[15:0] = cr_dq_i;
            end
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q  <= StIdle;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            rdat_q   <= '0;
            ack_q    <= 1'b0;
            rd_cap_q <= 1'b0;
            cap_hi_q <= 1'b0;
            addr_q   <= '0;
            dq_q     <= '0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            rdat_q   <= rdat_d;
            ack_q    <= ack_d;
            rd_cap_q <= rd_cap_d;
            cap_hi_q <= cap_hi_d;
            addr_q   <= addr_d;
            dq_q     <= dq_d;
            dq_oe_q  <= dq_oe_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            ub_n_q   <= ub_n_d;
            lb_n_q   <= lb_n_d;
        end
    end

    assign wb.wb_dat_o = rdat_q;
    assign wb.wb_ack_o = ack_q;
    assign cr_addr_o   = addr_q;
    assign cr_dq_o     = dq_q;
    assign cr_dq_oe    = dq_oe_q;
    assign cr_ce_n     = ce_n_q;
    assign cr_oe_n     = oe_n_q;
    assign cr_we_n     = we_n_q;
    assign cr_ub_n     = ub_n_q;
    assign cr_lb_n     = lb_n_q;
    assign cr_adv_n    = 1'b0;
    assign cr_clk      = 1'b0;
    assign cr_cre      = 1'b0;

endmodule

// File: tb/tb_cellram_wb_ctrl.sv
// Directed bench for cellram_wb_ctrl with a small byte-laned PSRAM model.
module tb_cellram_wb_ctrl;

`ifdef CELLRAM_WR_SKIP_EN
    localparam int SelAckK = 9;
    localparam int SelWeN  = 8;
`else
    localparam int SelAckK = 18;
    localparam int SelWeN  = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cellram_wb_ctrl_if wb();

    logic [22:0] cr_addr;
    logic [15:0] cr_dq_i, cr_dq_o;
    logic        cr_dq_oe, ce_n, oe_n, we_n, ub_n, lb_n, adv_n, cr_clk, cre;
    logic [15:0] mem [0:63];

    assign cr_dq_i = (!ce_n && !oe_n) ? mem[cr_addr[5:0]] : 16'h0000;

    cellram_wb_ctrl dut (
        .wb_clk    (clk),
        .wb_rst    (rst),
        .wb        (wb),
        .cr_addr_o (cr_addr),
        .cr_dq_i   (cr_dq_i),
        .cr_dq_o   (cr_dq_o),
        .cr_dq_oe  (cr_dq_oe),
        .cr_ce_n   (ce_n),
        .cr_oe_n   (oe_n),
        .cr_we_n   (we_n),
        .cr_ub_n   (ub_n),
        .cr_lb_n   (lb_n),
        .cr_adv_n  (adv_n),
        .cr_clk    (cr_clk),
        .cr_cre    (cre)
    );

    int n_checks = 0;
    int n_errors = 0;

    int          ack_k [2];
    int          ce_fall [4];
    logic [22:0] fall_addr [4];
    logic [1:0]  fall_ublb [4];
    int          n_ack, n_fall, n_oe, n_we, n_dqoe;
    logic [31:0] rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
    endtask

    task automatic rst_checks(input string tag);
        check({tag, "_strb"}, 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1F);
        check({tag, "_tied"}, 32'({adv_n, cr_clk, cre}), 32'h0);
        check({tag, "_ack"}, 32'(wb.wb_ack_o), 32'h0);
        check({tag, "_dat"}, wb.wb_dat_o, 32'h0);
        check({tag, "_addr"}, 32'(cr_addr), 32'h0);
        check({tag, "_dq"}, 32'({cr_dq_oe, cr_dq_o}), 32'h0);
    endtask

    // Runs one transfer for win cycles; k counts posedges from the request edge E0.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int acks_want, input int drop_at,
                        input int win);
        logic prev_ce;
        wb.wb_adr_i = adr;
        wb.wb_dat_i = dat;
        wb.wb_sel_i = sel;
        wb.wb_we_i  = we;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        n_ack = 0; n_fall = 0; n_oe = 0; n_we = 0; n_dqoe = 0;
        ack_k[0] = -1; ack_k[1] = -1;
        for (int i = 0; i < 4; i++) begin
            ce_fall[i] = -1; fall_addr[i] = '0; fall_ublb[i] = 2'b11;
        end
        prev_ce = 1'b1;
        for (int k = 0; k < win; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!ce_n && prev_ce) begin
                if (n_fall < 4) begin
                    ce_fall[n_fall]   = k;
                    fall_addr[n_fall] = cr_addr;
                    fall_ublb[n_fall] = {ub_n, lb_n};
                end
                n_fall++;
            end
            prev_ce = ce_n;
            if (!oe_n) n_oe++;
            if (!we_n) n_we++;
            if (cr_dq_oe) n_dqoe++;
            if (!ce_n && !we_n && cr_dq_oe) begin
                if (!ub_n) mem[cr_addr[5:0]][15:8] = cr_dq_o[15:8];
                if (!lb_n) mem[cr_addr[5:0]][7:0]  = cr_dq_o[7:0];
            end
            if (wb.wb_ack_o) begin
                if (n_ack < 2) ack_k[n_ack] = k;
                n_ack++;
                rdata = wb.wb_dat_o;
                if (n_ack >= acks_want) bus_idle();
            end
            if (k == drop_at) bus_idle();
        end
        bus_idle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[8]  = 16'h1234;
        mem[9]  = 16'hABCD;
        mem[20] = 16'h1122;
        mem[21] = 16'h3344;
        wb.wb_adr_i = '0;
        wb.wb_dat_i = '0;
        wb.wb_sel_i = '0;
        wb.wb_we_i  = 1'b0;
        bus_idle();
        rdata = '0;

        repeat (3) @(negedge clk);
        rst_checks("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Read of two halfwords, big-endian.
        xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1, -1, 24);
        check("rd_data", rdata, 32'h1234_ABCD);
        check("rd_ack_edge", 32'(ack_k[0]), 32'd18);
        check("rd_ack_cycles", 32'(n_ack), 32'd1);
        check("rd_acc0_start", 32'(ce_fall[0]), 32'd1);
        check("rd_addr0", 32'(fall_addr[0]), 32'd8);
        check("rd_addr1", 32'(fall_addr[1]), 32'd9);
        check("rd_oe_cycles", 32'(n_oe), 32'd16);
        check("rd_ublb", 32'({fall_ublb[0], fall_ublb[1]}), 32'h0);

        // Full-word write with data hold.
        xfer(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 1, -1, 24);
        check("wr_mem16", 32'(mem[16]), 32'h0000_DEAD);
        check("wr_mem17", 32'(mem[17]), 32'h0000_BEEF);
        check("wr_we_cycles", 32'(n_we), 32'd16);
        check("wr_dqoe_cycles", 32'(n_dqoe), 32'd18);
        check("wr_ack_edge", 32'(ack_k[0]), 32'd18);

        // Single byte lane in halfword 0.
        xfer(1'b1, 32'h0000_0028, 32'h0055_0000, 4'b0100, 1, -1, 24);
        check("sel_ublb0", 32'(fall_ublb[0]), 32'h2);
        check("sel_addr0", 32'(fall_addr[0]), 32'd20);
        check("sel_mem20", 32'(mem[20]), 32'h0000_1155);
        check("sel_mem21", 32'(mem[21]), 32'h0000_3344);
        check("sel_ack_edge", 32'(ack_k[0]), 32'(SelAckK));
        check("sel_we_cycles", 32'(n_we), 32'(SelWeN));

        // Back-to-back reads with stb held through the first ack.
        xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, 2, -1, 44);
        check("b2b_acks", 32'(n_ack), 32'd2);
        check("b2b_gap", 32'(ce_fall[2] >= ack_k[0] + 2), 32'd1);
        check("b2b_data", rdata, 32'h1234_ABCD);

        // cyc drops during ACC0: half 0 completes, no ack, partial data kept.
        xfer(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 3, 16);
        check("drop_acks", 32'(n_ack), 32'd0);
        check("drop_oe_cycles", 32'(n_oe), 32'd8);
        check("drop_dat", wb.wb_dat_o, 32'hDEAD_ABCD);
        check("drop_strb", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1F);

        // Asynchronous reset in the middle of ACC1 of a write.
        wb.wb_adr_i = 32'h0000_0030;
        wb.wb_dat_i = 32'h1234_5678;
        wb.wb_sel_i = 4'hF;
        wb.wb_we_i  = 1'b1;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        repeat (13) @(posedge clk);
        @(negedge clk);
        check("rst_pre_we", 32'(we_n), 32'd0);
        rst = 1'b1;
        #1;
        rst_checks("rst_mid");
        bus_idle();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        xfer(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1, -1, 24);
        check("post_rst_data", rdata, 32'hDEAD_BEEF);
        check("post_rst_ack_edge", 32'(ack_k[0]), 32'd18);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cellram_wb_ctrl.md
# cellram_wb_ctrl

Wishbone classic slave that owns the Nexys3 cellular RAM (PSRAM) and answers the single slave port driven by the cellram arbiter. Each 32-bit Wishbone access becomes two sequential 16-bit asynchronous-mode PSRAM accesses with programmable cycle counts. The result is returned with a single-cycle ack, well inside the arbiter's 1023-cycle timeout.

## Interface
Parameters:
- RD_CYCLES, 8, cycles CE#/OE# held low per halfword read (1..15)
- WR_CYCLES, 8, cycles CE#/WE# held low per halfword write (1..15)
- TURN_CYCLES, 1, CE#-high recovery cycles between the two halfwords (1..15)

Ports (one clock `wb_clk`; reset `wb_rst` is asynchronous and active-high):
- wb_clk  in  1  system clock
- wb_rst  in  1  asynchronous active-high reset
- wb_adr_i  in  32  byte address; [23:2] used, others ignored
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lanes
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic controls
- wb_dat_o  out  32  read data, registered
- wb_ack_o  out  1  one-cycle ack
- cr_addr_o  out  23  halfword address
- cr_dq_i  in  16  PSRAM data in
- cr_dq_o  out  16  PSRAM data out
- cr_dq_oe  out  1  tristate enable (top level builds the inout)
- cr_ce_n, cr_oe_n, cr_we_n, cr_ub_n, cr_lb_n  out  1 each  PSRAM strobes
- cr_adv_n, cr_clk, cr_cre  out  1 each  tied 0 (asynchronous mode)

## Operation
- Big-endian halfword mapping. Halfword 0 is at cr_addr_o={adr[23:2],0} and carries dat[31:16], sel[3]→UB#, sel[2]→LB#. Halfword 1 is at {adr[23:2],1} and carries dat[15:0], sel[1]→UB#, sel[0]→LB#.
- FSM states: IDLE → ACC0 → TURN → ACC1 → ACK → IDLE.
- IDLE: the request, cyc&stb, is sampled here. On request, address, data, sel and we are latched into registers.
- ACCn: ce_n=0, plus oe_n=0 (read) or we_n=0 (write). The phase down-counter is loaded with RD_CYCLES/WR_CYCLES.
  - On a read's last cycle, cr_dq_i is captured into the matching half of wb_dat_o.
  - On a write, cr_dq_oe=1 from ACC entry through the following TURN/ACK cycle for data hold.
- TURN: all strobes high, TURN_CYCLES long.
- ACK: wb_ack_o=1 for exactly one cycle, then IDLE. IDLE does not re-sample the request in the ACK cycle, so at least one idle cycle separates transactions.
- cyc_i falling mid-transaction: the current ACCn completes, then the FSM goes to IDLE. No ack is issued; wb_dat_o keeps its partial contents.
- Reads always access both halfwords. UB#/LB# are 0 on reads regardless of sel.
- Reset values: wb_ack_o=0, wb_dat_o=0, cr_addr_o=0, cr_dq_o=0, cr_dq_oe=0, cr_ce_n=cr_oe_n=cr_we_n=cr_ub_n=cr_lb_n=1, cr_adv_n=cr_clk=cr_cre=0, state IDLE. Reset mid-access returns these values immediately (asynchronous).

## Timing
- Request sampled at edge E0. ACC0 starts at E1.
- Read: ack rises at E(2·RD_CYCLES+TURN_CYCLES+1). With defaults this is E18.
- Write: ack rises at E(2·WR_CYCLES+TURN_CYCLES+1). With defaults this is E18.
- All PSRAM outputs are registered; no combinational path from wb_* to cr_*.
- Worst case with all parameters at 15: 46 cycles, which is less than 1023.

## Configuration
- CELLRAM_WR_SKIP_EN defined:
  - A write halfword whose two sel bits are both 0 is skipped, along with its adjacent TURN.
  - sel=4'b0011: only ACC1 runs, ack at E(WR_CYCLES+1).
  - sel=4'b1100: only ACC0 runs, ack at E(WR_CYCLES+1).
  - sel=4'b0000 write: ack at E1 with no PSRAM activity.
- CELLRAM_WR_SKIP_EN undefined: both halfwords are always accessed; masked lanes keep UB#/LB# high.

## Structure
- Package cellram_pkg holds:
  - the state enum (IDLE, ACC0, TURN, ACC1, ACK)
  - default cycle-count constants
  - the 4-bit phase-counter width
- Sub-module cellram_phase_timer: a loadable 4-bit down-counter with a `done` output when it reaches 1. It is instantiated once and shared by the ACC and TURN phases.

## Test plan
- Read adr=0x0000_0010 with PSRAM model returning 0x1234 at halfword 8 and 0xABCD at halfword 9 → cr_addr_o 8 then 9, wb_dat_o=0x1234ABCD, ack at E18, ack high one cycle.
- Write adr=0x0000_0020, dat=0xDEADBEEF, sel=4'hF → halfword 16 gets 0xDEAD, halfword 17 gets 0xBEEF, we_n low 8 cycles each, cr_dq_oe held through the hold cycle, ack at E18.
- Write sel=4'b0100, dat=0x00550000 → only LB# low in ACC0, memory byte updated to 0x55. With CELLRAM_WR_SKIP_EN, ACC1 is absent and ack is at E9.
- Back-to-back reads with stb held high across ack → second ACC0 starts no earlier than two cycles after ack, and exactly one ack per transaction.
- Drop cyc_i during ACC0 of a read → ACC0 finishes, no ack, FSM returns to IDLE, all strobes high.
- Assert wb_rst mid-ACC1 write → all outputs take their reset values immediately; the next request after reset completes normally.
